// File: rtl/dram_responder_pkg.sv
// -----------------------------------------------------------------------------
// dram_responder_pkg
// Shared constants for the MEM-stage data-memory responder: FSM state
// encodings, default geometry/timing parameters and small address helpers.
// -----------------------------------------------------------------------------
package dram_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dram_state_e;

   localparam int unsigned ADDR_W_DEF      = 14;
   localparam int unsigned WAIT_CYCLES_DEF = 2;
   localparam int unsigned WAIT_CNT_W      = 4;   // holds 0..15 wait states

   // Word accesses only: any nonzero byte offset is reported as an error.
   function automatic logic is_misaligned(input logic [1:0] byte_off);
      return (byte_off != 2'b00);
   endfunction

endpackage : dram_responder_pkg

// File: rtl/dram_responder_if.sv
// -----------------------------------------------------------------------------
// dram_responder_if
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave). Suffixes are from the responder's point of view.
//   req_valid_i  - request present, held until resp_valid_o
//   req_we_i     - 1 = store, 0 = load
//   req_addr_i   - byte address
//   req_wdata_i  - store data
//   req_ready_o  - responder idle and able to accept
//   resp_valid_o - one-cycle completion pulse
//   resp_rdata_o - load data
//   resp_err_o   - misaligned access flag
//   stall_o      - freeze for upstream pipeline registers
// -----------------------------------------------------------------------------
interface dram_responder_if;

   logic        req_valid_i;
   logic        req_we_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        req_ready_o;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        stall_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o
   );

endinterface : dram_responder_if

// File: rtl/dram_word_ram.sv
// -----------------------------------------------------------------------------
// dram_word_ram
// Synchronous single-port word RAM, 2^ADDR_W x 32. Contents are not reset.
//   clk_i    - clock
//   en_i     - access enable (one cycle per access)
//   we_i     - 1 = write wdata_i, 0 = read into rdata_o
//   addr_i   - word index
//   wdata_i  - write data
//   rdata_o  - registered read data; only changes on an enabled read
// -----------------------------------------------------------------------------
module dram_word_ram #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [2**ADDR_W];

   // rdata_o holds between reads; the responder relies on this to keep its
   // response data stable after the RESP cycle.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_o <= mem_q[addr_i];
         end
      end
   end

endmodule : dram_word_ram

// File: rtl/dram_responder.sv
// -----------------------------------------------------------------------------
// dram_responder
// Data-memory responder for the MEM stage. Accepts one word load/store at a
// time, waits WAIT_CYCLES extra cycles, performs the RAM access on the edge
// leaving WAIT and returns a one-cycle response. stall_o holds the pipeline
// while a request is outstanding.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - request/response bundle (slave side)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready; a valid request is latched and the wait counter loaded
// ST_WAIT | counting down wait states; access fires when the count is 0
// ST_RESP | resp_valid_o pulse; always returns to ST_IDLE next edge
// -----------------------------------------------------------------------------
module dram_responder
   import dram_responder_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   dram_responder_if.slave bus
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

   dram_state_e           state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_W-1:0]     idx_q, idx_d;
   logic                  mis_q, mis_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  load_ok_q, load_ok_d;
   logic                  err_q, err_d;

   logic                  access_go;
   logic                  ram_en;
   logic [31:0]           ram_rdata;

   // Only the word index and the byte offset are kept; upper address bits
   // alias by design.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      idx_d     = idx_q;
      mis_d     = mis_q;
      wdata_d   = wdata_q;
      access_go = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid_i) begin
               we_d    = bus.req_we_i;
               idx_d   = bus.req_addr_i[ADDR_W+1:2];
               mis_d   = is_misaligned(bus.req_addr_i[1:0]);
               wdata_d = bus.req_wdata_i;
               cnt_d   = WAIT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               access_go = 1'b1;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // load_ok_q selects RAM data onto resp_rdata_o. It only changes together
   // with a RAM access, so the output holds its last value outside RESP.
   always_comb begin
      load_ok_d = load_ok_q;
      err_d     = 1'b0;
      if (access_go) begin
         load_ok_d = ~we_q & ~mis_q;
         err_d     = mis_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         idx_q     <= '0;
         mis_q     <= 1'b0;
         wdata_q   <= '0;
         load_ok_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         idx_q     <= idx_d;
         mis_q     <= mis_d;
         wdata_q   <= wdata_d;
         load_ok_q <= load_ok_d;
         err_q     <= err_d;
      end
   end

   // Misaligned accesses never touch the RAM.
   assign ram_en = access_go & ~mis_q;

   dram_word_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk),
      .en_i    (ram_en),
      .we_i    (we_q),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   assign bus.req_ready_o  = (state_q == ST_IDLE);
   assign bus.resp_valid_o = (state_q == ST_RESP);
   assign bus.resp_err_o   = err_q;
   assign bus.resp_rdata_o = load_ok_q ? ram_rdata : 32'h0;
   assign bus.stall_o      = bus.req_valid_i & ~bus.resp_valid_o;

endmodule : dram_responder
